// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//   One-stage MIPS-subset decode with a valid/ready handshake on both sides.
//   An accepted instruction word is decoded combinationally and registered, so
//   the decoded bundle appears one cycle after the accept edge and is held
//   until the downstream register-file read stage takes it.
//
//   Supported: R-type ADD/SUB/AND/OR/SLT, ADDI, ANDI, ORI, LW, SW, BEQ.
//   Anything else decodes as a NOP (all controls and immediate zero) but still
//   transfers and counts.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake; instr and pc qualified by in_valid
//   out_valid/out_ready   downstream handshake for the decoded bundle
//   Read_register1/2      rs / rt, zero-extended to 32 bits
//   Write_register        destination register index (0 = none)
//   imm                   extended immediate (BEQ: byte offset, already << 2)
//   alu_op                0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
//   reg_write, mem_read, mem_write, branch, use_imm   control bits
//   pc_out                pc of the held instruction
//   decode_count          instructions accepted since reset (wraps)
//   illegal               unsupported encoding flag (only with the macro below)
//
// Build option
//   ID_ILLEGAL_TRAP_EN    adds the registered 'illegal' output
// -----------------------------------------------------------------------------
module instr_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Read_register1,
  output logic [31:0] Read_register2,
  output logic [4:0]  Write_register,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        use_imm,
  output logic [31:0] pc_out,
  output logic [31:0] decode_count
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] simm;
  logic [31:0] zimm;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign simm   = {{16{instr[15]}}, instr[15:0]};
  assign zimm   = {16'h0000, instr[15:0]};

  // Shift amount field is not consumed by any supported operation.
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  logic [4:0]  d_wr;
  logic [31:0] d_imm;
  logic [3:0]  d_alu;
  logic        d_rw_raw;
  logic        d_rw;
  logic        d_mr;
  logic        d_mw;
  logic        d_br;
  logic        d_ui;
  logic        d_legal;

  always_comb begin
    d_wr     = 5'd0;
    d_imm    = 32'h0;
    d_alu    = ALU_ADD;
    d_rw_raw = 1'b0;
    d_mr     = 1'b0;
    d_mw     = 1'b0;
    d_br     = 1'b0;
    d_ui     = 1'b0;
    d_legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        d_wr     = rd;
        d_rw_raw = 1'b1;
        case (funct)
          FN_ADD:  d_alu = ALU_ADD;
          FN_SUB:  d_alu = ALU_SUB;
          FN_AND:  d_alu = ALU_AND;
          FN_OR:   d_alu = ALU_OR;
          FN_SLT:  d_alu = ALU_SLT;
          default: begin
            d_legal  = 1'b0;
            d_wr     = 5'd0;
            d_rw_raw = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        d_wr     = rt;
        d_rw_raw = 1'b1;
        d_ui     = 1'b1;
        // Logical immediates are zero-extended, arithmetic ones sign-extended.
        if (opcode == OP_ADDI) begin
          d_alu = ALU_ADD;
          d_imm = simm;
        end else if (opcode == OP_ANDI) begin
          d_alu = ALU_AND;
          d_imm = zimm;
        end else begin
          d_alu = ALU_OR;
          d_imm = zimm;
        end
      end
      OP_LW: begin
        d_wr     = rt;
        d_rw_raw = 1'b1;
        d_mr     = 1'b1;
        d_ui     = 1'b1;
        d_imm    = simm;
      end
      OP_SW: begin
        d_mw  = 1'b1;
        d_ui  = 1'b1;
        d_imm = simm;
      end
      OP_BEQ: begin
        d_br  = 1'b1;
        d_alu = ALU_SUB;
        d_imm = {simm[29:0], 2'b00};
      end
      default: d_legal = 1'b0;
    endcase
  end

  // Writes to $zero are architecturally dropped, so never request them.
  assign d_rw = d_rw_raw && (d_wr != 5'd0);

  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  logic [4:0] rs_q;
  logic [4:0] rt_q;

  assign Read_register1 = {27'b0, rs_q};
  assign Read_register2 = {27'b0, rt_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      rs_q           <= 5'd0;
      rt_q           <= 5'd0;
      Write_register <= 5'd0;
      imm            <= 32'h0;
      alu_op         <= 4'd0;
      reg_write      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      branch         <= 1'b0;
      use_imm        <= 1'b0;
      pc_out         <= 32'h0;
      decode_count   <= 32'h0;
`ifdef ID_ILLEGAL_TRAP_EN
      illegal        <= 1'b0;
`endif
    end else if (accept) begin
      out_valid      <= 1'b1;
      rs_q           <= rs;
      rt_q           <= rt;
      Write_register <= d_wr;
      imm            <= d_imm;
      alu_op         <= d_alu;
      reg_write      <= d_rw;
      mem_read       <= d_mr;
      mem_write      <= d_mw;
      branch         <= d_br;
      use_imm        <= d_ui;
      pc_out         <= pc;
      decode_count   <= decode_count + 32'd1;
`ifdef ID_ILLEGAL_TRAP_EN
      illegal        <= !d_legal;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifndef ID_ILLEGAL_TRAP_EN
  logic unused_legal;
  assign unused_legal = d_legal;
`endif

endmodule
